// File: rtl/msrr_n.sv
// Multi-mode shift/rotate register with a burst engine.
// Idle steps continuously; start runs exactly amt steps of the latched mode and then pulses done.
module msrr_n #(
    parameter int WIDTH = 8,
    localparam int AW = $clog2(WIDTH) + 1
) (
    input  logic             clc,
    input  logic             R,
    input  logic             sInR,
    input  logic             sInL,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] pIn,
    output logic [WIDTH-1:0] Q,
    output logic             sOutR,
    output logic             sOutL,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [AW-1:0]    cnt_reg, cnt_next;
    logic [2:0]       mode_reg, mode_next;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q;

    // Idle runs the live mode; a burst runs the mode captured with start.
    assign step_mode = (state_reg == BUSY) ? mode_reg : mode;

    always_comb begin
        step_q = q_reg;
        case (step_mode)
            3'b000:  step_q = q_reg;
            3'b001:  step_q = {sInR, q_reg[WIDTH-1:1]};
            3'b010:  step_q = {q_reg[WIDTH-2:0], sInL};
            3'b011:  step_q = {q_reg[0], q_reg[WIDTH-1:1]};
            3'b100:  step_q = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
            3'b101:  step_q = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
            3'b110:  step_q = pIn;
            3'b111:  step_q = '0;
            default: step_q = q_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    // The start edge only captures the request; stepping begins on the next edge.
                    mode_next  = mode;
                    cnt_next   = amt;
                    state_next = (amt != '0) ? BUSY : DONE;
                end else begin
                    q_next = step_q;
                end
            end
            BUSY: begin
                q_next   = step_q;
                cnt_next = cnt_reg - AW'(1);
                if (cnt_reg == AW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clc or negedge R) begin
        if (!R) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            cnt_reg   <= '0;
            mode_reg  <= 3'b000;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
        end
    end

    assign Q     = q_reg;
    assign sOutR = q_reg[0];
    assign sOutL = q_reg[WIDTH-1];
    assign busy  = (state_reg == BUSY);
    assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_msrr_n.sv
// Self-checking bench for msrr_n: directed scenarios plus randomized continuous and burst traffic
// compared against an arithmetic reference model of the register.
module tb_msrr_n;

    localparam int W  = 8;
    localparam int AW = $clog2(W) + 1;

    logic          clc = 1'b0;
    logic          R;
    logic          sInR, sInL;
    logic [2:0]    mode;
    logic          start;
    logic [AW-1:0] amt;
    logic [W-1:0]  pIn;
    logic [W-1:0]  Q;
    logic          sOutR, sOutL, busy, done;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] mq;

    always #5 clc = ~clc;

    msrr_n #(.WIDTH(W)) dut (
        .clc(clc), .R(R), .sInR(sInR), .sInL(sInL), .mode(mode), .start(start),
        .amt(amt), .pIn(pIn), .Q(Q), .sOutR(sOutR), .sOutL(sOutL), .busy(busy), .done(done)
    );

    // One step of the register, expressed as integer arithmetic on the value.
    function automatic logic [W-1:0] model_step(input logic [2:0] m, input logic [W-1:0] q,
                                                input logic sr, input logic sl, input logic [W-1:0] p);
        int v, msb, mask;
        v    = int'(q);
        msb  = 1 << (W - 1);
        mask = (1 << W) - 1;
        case (m)
            3'd1:    v = (v / 2) + (sr ? msb : 0);
            3'd2:    v = ((v * 2) & mask) + (sl ? 1 : 0);
            3'd3:    v = (v / 2) + ((v % 2) * msb);
            3'd4:    v = ((v * 2) & mask) + (v / msb);
            3'd5:    v = (v / 2) + (v & msb);
            3'd6:    v = int'(p);
            3'd7:    v = 0;
            default: v = v;
        endcase
        return v[W-1:0];
    endfunction

    task automatic tick();
        @(posedge clc);
        #1;
    endtask

    task automatic preload(input logic [W-1:0] val);
        start = 1'b0;
        mode  = 3'b110;
        pIn   = val;
        tick();
        mq    = val;
        mode  = 3'b000;
        if (Q !== mq) begin
            bad++;
            $display("FAIL preload: Q=%h expected %h", Q, mq);
        end
        total++;
    endtask

    task automatic test_reset();
        R = 1'b0; sInR = 0; sInL = 0; mode = 3'b000; start = 0; amt = '0; pIn = '0;
        #1;
        if ({Q, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_init: Q=%h busy=%b done=%b expected 00 0 0", Q, busy, done);
        end
        total++;
        @(negedge clc);
        R = 1'b1;
        preload(8'hFF);
        #2;
        R = 1'b0;
        #1;
        if ({Q, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_async: Q=%h busy=%b done=%b expected 00 0 0", Q, busy, done);
        end
        total++;
        @(negedge clc);
        R  = 1'b1;
        mq = '0;
        $display("test_reset: checks so far %0d", total);
    endtask

    task automatic test_load_rotate();
        preload(8'hA5);
        mode = 3'b011;
        tick();
        mode = 3'b000;
        if ({Q, sOutR, sOutL} !== {8'hD2, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL load_rotate: Q=%h sOutR=%b sOutL=%b expected D2 0 1", Q, sOutR, sOutL);
        end
        total++;
        mq = 8'hD2;
        $display("test_load_rotate: checks so far %0d", total);
    endtask

    task automatic test_burst_rotate();
        logic [W-1:0] exp_q [3] = '{8'h03, 8'h06, 8'h0C};
        preload(8'h81);
        start = 1'b1; mode = 3'b100; amt = AW'(3);
        tick();
        start = 1'b0; mode = 3'b000;
        if ({Q, busy, done} !== {8'h81, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL burst_rotate_start: Q=%h busy=%b done=%b expected 81 1 0", Q, busy, done);
        end
        total++;
        for (int j = 0; j < 3; j++) begin
            tick();
            if ({Q, busy, done} !== {exp_q[j], (j < 2), (j == 2)}) begin
                bad++;
                $display("FAIL burst_rotate_step%0d: Q=%h busy=%b done=%b expected %h %b %b",
                         j + 1, Q, busy, done, exp_q[j], (j < 2), (j == 2));
            end
            total++;
        end
        tick();
        if ({Q, busy, done} !== {8'h0C, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL burst_rotate_idle: Q=%h busy=%b done=%b expected 0C 0 0", Q, busy, done);
        end
        total++;
        mq = 8'h0C;
        $display("test_burst_rotate: checks so far %0d", total);
    endtask

    task automatic test_burst_asr();
        logic [W-1:0] exp_q [2] = '{8'hC8, 8'hE4};
        preload(8'h90);
        start = 1'b1; mode = 3'b101; amt = AW'(2);
        tick();
        start = 1'b0; mode = 3'b000;
        for (int j = 0; j < 2; j++) begin
            tick();
            if ({Q, busy, done} !== {exp_q[j], (j < 1), (j == 1)}) begin
                bad++;
                $display("FAIL burst_asr_step%0d: Q=%h busy=%b done=%b expected %h %b %b",
                         j + 1, Q, busy, done, exp_q[j], (j < 1), (j == 1));
            end
            total++;
        end
        tick();
        if ({Q, busy, done} !== {8'hE4, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL burst_asr_idle: Q=%h busy=%b done=%b expected E4 0 0", Q, busy, done);
        end
        total++;
        mq = 8'hE4;
        $display("test_burst_asr: checks so far %0d", total);
    endtask

    task automatic test_amt_zero();
        preload(8'h3C);
        start = 1'b1; mode = 3'b001; amt = '0; sInR = 1'b1;
        tick();
        if ({Q, busy, done} !== {8'h3C, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL amt_zero_done: Q=%h busy=%b done=%b expected 3C 0 1", Q, busy, done);
        end
        total++;
        tick();
        if ({Q, busy, done} !== {8'h3C, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL amt_zero_idle: Q=%h busy=%b done=%b expected 3C 0 0", Q, busy, done);
        end
        total++;
        start = 1'b0; mode = 3'b000;
        mq = 8'h3C;
        $display("test_amt_zero: checks so far %0d", total);
    endtask

    task automatic test_reset_midburst();
        preload(8'h5A);
        start = 1'b1; mode = 3'b010; amt = AW'(5); sInL = 1'b1;
        tick();
        for (int j = 1; j <= 2; j++) begin
            mq = model_step(3'b010, mq, sInR, sInL, pIn);
            tick();
            if ({Q, busy, done} !== {mq, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL midburst_step%0d: Q=%h busy=%b done=%b expected %h 1 0", j, Q, busy, done, mq);
            end
            total++;
        end
        R = 1'b0;
        #1;
        if ({Q, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midburst_reset: Q=%h busy=%b done=%b expected 00 0 0", Q, busy, done);
        end
        total++;
        @(negedge clc);
        R = 1'b1; start = 1'b0; mode = 3'b000;
        mq = '0;
        for (int j = 0; j < 7; j++) begin
            tick();
            if ({Q, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL midburst_after%0d: Q=%h busy=%b done=%b expected 00 0 0", j, Q, busy, done);
            end
            total++;
        end
        $display("test_reset_midburst: checks so far %0d", total);
    endtask

    task automatic test_random_continuous();
        start = 1'b0;
        for (int i = 0; i < 150; i++) begin
            mode = 3'($urandom_range(0, 7));
            sInR = 1'($urandom); sInL = 1'($urandom);
            pIn  = W'($urandom); amt = AW'($urandom);
            mq   = model_step(mode, mq, sInR, sInL, pIn);
            tick();
            if ({Q, sOutR, sOutL, busy, done} !== {mq, mq[0], mq[W-1], 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL cont%0d mode=%0d: Q=%h sOutR=%b sOutL=%b busy=%b done=%b expected %h %b %b 0 0",
                         i, mode, Q, sOutR, sOutL, busy, done, mq, mq[0], mq[W-1]);
            end
            total++;
        end
        mode = 3'b000;
        $display("test_random_continuous: checks so far %0d", total);
    endtask

    task automatic test_random_burst();
        logic [2:0] m;
        int         a;
        for (int b = 0; b < 40; b++) begin
            preload(W'($urandom));
            m = 3'($urandom_range(0, 7));
            a = $urandom_range(0, (1 << AW) - 1);
            start = 1'b1; mode = m; amt = AW'(a);
            tick();
            if ({Q, busy, done} !== {mq, (a != 0), (a == 0)}) begin
                bad++;
                $display("FAIL burst%0d_start: Q=%h busy=%b done=%b expected %h %b %b",
                         b, Q, busy, done, mq, (a != 0), (a == 0));
            end
            total++;
            for (int j = 1; j <= a; j++) begin
                // Live controls are scrambled to show they do not disturb the burst.
                start = 1'($urandom); mode = 3'($urandom); amt = AW'($urandom);
                sInR  = 1'($urandom); sInL = 1'($urandom); pIn = W'($urandom);
                mq    = model_step(m, mq, sInR, sInL, pIn);
                tick();
                if ({Q, busy, done} !== {mq, (j < a), (j == a)}) begin
                    bad++;
                    $display("FAIL burst%0d_step%0d mode=%0d amt=%0d: Q=%h busy=%b done=%b expected %h %b %b",
                             b, j, m, a, Q, busy, done, mq, (j < a), (j == a));
                end
                total++;
            end
            start = 1'($urandom); mode = 3'($urandom);
            tick();
            if ({Q, busy, done} !== {mq, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL burst%0d_idle: Q=%h busy=%b done=%b expected %h 0 0", b, Q, busy, done, mq);
            end
            total++;
            start = 1'b0; mode = 3'b000;
            $display("burst %0d mode=%0d amt=%0d final Q=%h", b, m, a, Q);
        end
        $display("test_random_burst: checks so far %0d", total);
    endtask

    initial begin
        test_reset();
        test_load_rotate();
        test_burst_rotate();
        test_burst_asr();
        test_amt_zero();
        test_reset_midburst();
        test_random_continuous();
        test_random_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
